// File: rtl/i2c_xfer_pkg.sv
// Shared types and constants for the I2C slave transaction controller.
package i2c_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } xfer_state_t;

    localparam int DEPTH_LOG2_DEF = 4;
    localparam int WDOG_W         = 16;

    // One extra wrap bit distinguishes full from empty.
    function automatic int ptr_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/i2c_cmt_fifo.sv
// 32-bit word FIFO with a speculative/commit pointer pair on one side.
// SPEC_RD=1: read side is speculative (TX); SPEC_RD=0: write side is speculative (RX).
module i2c_cmt_fifo
    import i2c_xfer_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter bit SPEC_RD    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [31:0]           i_wdata,
    input  logic                  i_pop,
    input  logic                  i_commit,
    input  logic                  i_rewind,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_cnt,
    output logic [31:0]           o_rdata,
    output logic                  o_pend
);
    localparam int PW = ptr_w(DEPTH_LOG2);
    localparam logic [PW-1:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [PW-1:0] r_wr, r_rd, r_cmt;
    logic [31:0]   r_mem [2**DEPTH_LOG2];
    logic          w_push_ok, w_pop_ok;

    // r_cmt trails the speculative pointer; the host-facing flags use it.
    generate
        if (SPEC_RD) begin : g_tx
            assign o_full  = (r_wr - r_cmt) == FULL_CNT;
            assign o_empty = r_wr == r_rd;
            assign o_cnt   = r_wr - r_cmt;
            assign o_pend  = r_rd != r_cmt;
        end else begin : g_rx
            assign o_full  = (r_wr - r_rd) == FULL_CNT;
            assign o_empty = r_cmt == r_rd;
            assign o_cnt   = r_cmt - r_rd;
            assign o_pend  = r_wr != r_cmt;
        end
    endgenerate

    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rd[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr[DEPTH_LOG2-1:0]] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cmt <= '0;
        end else if (SPEC_RD) begin
            if (w_push_ok)
                r_wr <= r_wr + 1'b1;
            if (i_rewind)
                r_rd <= r_cmt;
            else if (w_pop_ok)
                r_rd <= r_rd + 1'b1;
            if (i_commit)
                r_cmt <= r_rd;
        end else begin
            if (i_rewind)
                r_wr <= r_cmt;
            else if (w_push_ok)
                r_wr <= r_wr + 1'b1;
            if (w_pop_ok)
                r_rd <= r_rd + 1'b1;
            if (i_commit)
                r_cmt <= r_wr;
        end
    end

endmodule

// File: rtl/i2c_xfer_ctrl.sv
// I2C slave transaction controller: commit/rewind RX and TX buffers, watchdog, irqs.
// Optional statistics counters built when I2C_XFER_CTRL_STAT_EN is defined.
module i2c_xfer_ctrl
    import i2c_xfer_pkg::*;
#(
    parameter int                DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter logic [6:0]        ADDR_RST   = 7'h40,
    parameter logic [WDOG_W-1:0] TIMEOUT    = 16'd50000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [6:0]            phy_addr,
    output logic                  phy_full,
    input  logic                  phy_push,
    input  logic [31:0]           phy_dout,
    output logic                  phy_empty,
    input  logic                  phy_pop,
    output logic [31:0]           phy_din,
    input  logic                  phy_wstop,
    input  logic                  phy_rstop,
    input  logic                  phy_rerr,
    input  logic                  cfg_addr_we,
    input  logic [6:0]            cfg_addr,
    input  logic                  tx_we,
    input  logic [31:0]           tx_data,
    output logic                  tx_full,
    output logic [DEPTH_LOG2:0]   tx_cnt,
    input  logic                  rx_re,
    output logic [31:0]           rx_data,
    output logic                  rx_empty,
    output logic [DEPTH_LOG2:0]   rx_cnt,
    output logic                  irq_rx,
    output logic                  irq_err,
    output logic [15:0]           stat_wr,
    output logic [15:0]           stat_rerr,
    output logic [15:0]           stat_tout
);
    xfer_state_t       r_state;
    logic [WDOG_W-1:0] r_wdog;
    logic [6:0]        r_addr;
    logic              r_ovf, r_irq_rx, r_irq_err;

    logic w_act, w_tout, w_ovf;
    logic w_rx_commit, w_rx_discard, w_rx_pend;
    logic w_tx_commit, w_tx_rewind, w_tx_pend;

    assign w_act  = phy_push | phy_pop | phy_wstop | phy_rstop | phy_rerr;
    assign w_tout = (r_state != ST_IDLE) && !w_act && (r_wdog == TIMEOUT - 1'b1);
    // A push into a full buffer in the stop cycle still poisons the transaction.
    assign w_ovf  = r_ovf | (phy_push & phy_full);

    assign w_rx_commit  = phy_wstop & ~w_ovf & w_rx_pend;
    assign w_rx_discard = (phy_wstop & w_ovf) | (w_tout & (r_state == ST_WR));
    assign w_tx_commit  = phy_rstop & ~phy_rerr & w_tx_pend;
    assign w_tx_rewind  = phy_rerr | (w_tout & (r_state == ST_RD));

    i2c_cmt_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .SPEC_RD(1'b0)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .i_push   (phy_push),
        .i_wdata  (phy_dout),
        .i_pop    (rx_re),
        .i_commit (w_rx_commit),
        .i_rewind (w_rx_discard),
        .o_full   (phy_full),
        .o_empty  (rx_empty),
        .o_cnt    (rx_cnt),
        .o_rdata  (rx_data),
        .o_pend   (w_rx_pend)
    );

    i2c_cmt_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .SPEC_RD(1'b1)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .i_push   (tx_we),
        .i_wdata  (tx_data),
        .i_pop    (phy_pop),
        .i_commit (w_tx_commit),
        .i_rewind (w_tx_rewind),
        .o_full   (tx_full),
        .o_empty  (phy_empty),
        .o_cnt    (tx_cnt),
        .o_rdata  (phy_din),
        .o_pend   (w_tx_pend)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_wdog    <= '0;
            r_addr    <= ADDR_RST;
            r_ovf     <= 1'b0;
            r_irq_rx  <= 1'b0;
            r_irq_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (phy_push)
                        r_state <= ST_WR;
                    else if (phy_pop)
                        r_state <= ST_RD;
                end
                ST_WR:   if (phy_wstop || w_tout) r_state <= ST_IDLE;
                ST_RD:   if (phy_rstop || phy_rerr || w_tout) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            r_wdog    <= (r_state == ST_IDLE || w_act || w_tout) ? '0 : r_wdog + 1'b1;
            r_ovf     <= w_rx_discard ? 1'b0 : w_ovf;
            r_irq_rx  <= w_rx_commit;
            r_irq_err <= w_rx_discard | w_tx_rewind;
            if (cfg_addr_we)
                r_addr <= cfg_addr;
        end
    end

    assign phy_addr = r_addr;
    assign irq_rx   = r_irq_rx;
    assign irq_err  = r_irq_err;

`ifdef I2C_XFER_CTRL_STAT_EN
    logic [15:0] r_stat_wr, r_stat_rerr, r_stat_tout;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_wr   <= '0;
            r_stat_rerr <= '0;
            r_stat_tout <= '0;
        end else begin
            if (w_rx_commit && r_stat_wr != 16'hFFFF)
                r_stat_wr <= r_stat_wr + 1'b1;
            if (phy_rerr && r_stat_rerr != 16'hFFFF)
                r_stat_rerr <= r_stat_rerr + 1'b1;
            if (w_tout && r_stat_tout != 16'hFFFF)
                r_stat_tout <= r_stat_tout + 1'b1;
        end
    end

    assign stat_wr   = r_stat_wr;
    assign stat_rerr = r_stat_rerr;
    assign stat_tout = r_stat_tout;
`else
    assign stat_wr   = '0;
    assign stat_rerr = '0;
    assign stat_tout = '0;
`endif

endmodule

// File: doc/i2c_xfer_ctrl.md
Name: i2c_xfer_ctrl

Overview:
Transaction controller between the I2C slave PHY and the host bus (CPU/register block). Owns the PHY's RX and TX word buffers, which hold 32-bit words. RX words become visible to the host only when the write transaction ends cleanly. TX words are retired only after a successful read; they are rewound for retransmit on a read error or timeout. Also holds the slave address register and raises host interrupts.

Parameters:
DEPTH_LOG2, 4, log2 of words per FIFO (RX and TX each hold 2**DEPTH_LOG2 words)
ADDR_RST, 7'h40, reset value of slave address
TIMEOUT, 16'd50000, clk cycles without PHY activity before an open transaction is aborted

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
phy_addr  out  7  slave address to PHY
phy_full  out  1  RX speculative FIFO full
phy_push  in  1  PHY writes phy_dout
phy_dout  in  32  received word
phy_empty  out  1  TX speculative FIFO empty
phy_pop  in  1  PHY consumes phy_din this cycle
phy_din  out  32  TX head word (fall-through)
phy_wstop  in  1  write transaction ended
phy_rstop  in  1  read transaction ended OK
phy_rerr  in  1  read arbitration/bit error
cfg_addr_we  in  1  load cfg_addr into phy_addr
cfg_addr  in  7  new slave address
tx_we  in  1  host TX write
tx_data  in  32  host TX word
tx_full  out  1  TX committed FIFO full
tx_cnt  out  DEPTH_LOG2+1  committed TX words
rx_re  in  1  host RX read (pop)
rx_data  out  32  RX head word (fall-through)
rx_empty  out  1  no committed RX words
rx_cnt  out  DEPTH_LOG2+1  committed RX words
irq_rx  out  1  pulse: write transaction committed
irq_err  out  1  pulse: overflow, rerr or timeout
stat_wr, stat_rerr, stat_tout  out  16 each  statistics (see Optional Feature)

Behaviour:
- Reset: phy_addr=ADDR_RST; all pointers 0; FSM IDLE; phy_full=0, phy_empty=1, tx_full=0, rx_empty=1, counts 0, irqs 0, stats 0.
- RX FIFO: write pointer wr_spec and commit pointer wr_cmt, plus host read pointer.
  - phy_push with space: store word, wr_spec++.
  - phy_push while phy_full: word dropped, ovf flag set.
  - phy_wstop with ovf=0: wr_cmt<=wr_spec, irq_rx pulse next cycle. Zero-word transaction: commit is a no-op, no irq.
  - phy_wstop with ovf=1: wr_spec<=wr_cmt (discard), irq_err pulse, ovf cleared.
  - phy_full=(wr_spec-rd)==depth. rx_empty/rx_cnt use wr_cmt.
- TX FIFO: host write pointer, speculative read rd_spec, commit rd_cmt.
  - phy_din=mem[rd_spec] combinationally. phy_pop: rd_spec++ at the same edge.
  - phy_rstop: rd_cmt<=rd_spec.
  - phy_rerr: rd_spec<=rd_cmt, irq_err pulse.
  - phy_empty=(wr==rd_spec). tx_full/tx_cnt use rd_cmt. tx_we while tx_full is ignored.
- Pointers are DEPTH_LOG2+1 bits with wrap-bit compare. All flags are registered-pointer derived, updated the cycle after the event.
- FSM states IDLE, WR, RD:
  - IDLE->WR on phy_push. IDLE->RD on phy_pop.
  - WR->IDLE on phy_wstop. RD->IDLE on phy_rstop or phy_rerr.
  - In WR/RD, a watchdog counter clears on any PHY input pulse and increments otherwise. At TIMEOUT-1 it aborts: WR discards like overflow, RD rewinds like rerr; irq_err pulses; FSM->IDLE.
  - Watchdog held 0 in IDLE.
- Simultaneous events:
  - tx_we and phy_pop in the same cycle are both honoured.
  - rx_re and phy_push/phy_wstop in the same cycle are both honoured; the count reflects both.
  - phy_pop with phy_rerr in the same cycle: the rewind wins.
  - cfg_addr_we takes effect next cycle, even mid-transaction.
- rx_re while rx_empty is ignored.

Optional Feature:
I2C_XFER_CTRL_STAT_EN:
- Defined: stat_wr counts committed write transactions, stat_rerr counts phy_rerr events, stat_tout counts timeouts. All are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: the three ports are driven constant 0 and no counter flops are built.

Decomposition:
- Package i2c_xfer_pkg: FSM state encoding (IDLE/WR/RD), default DEPTH_LOG2, watchdog width constant (16), pointer-width localparam function.
- One natural sub-module, i2c_cmt_fifo: a word FIFO with speculative/commit pointer pairs, parameter SPEC_RD selecting whether the speculative side is the read side (TX) or the write side (RX). It is instantiated twice.

Test Plan:
- Host writes 32'hA5A5_0001, 32'hA5A5_0002 to TX; PHY pops twice, phy_rstop -> phy_din sequence matches, tx_cnt 2->0 after rstop, phy_empty=1.
- TX holds 3 words; PHY pops 2, then phy_rerr -> irq_err pulse, phy_din returns 1st word, tx_cnt stays 3, stat_rerr=1 (with STAT_EN).
- PHY pushes 4 words then phy_wstop -> rx_empty drops only after wstop, rx_cnt=4, irq_rx one pulse, host reads words in order.
- DEPTH_LOG2=4: PHY pushes 17 words, then wstop -> phy_full asserted after 16th, rx_cnt stays 0, irq_err pulse, FIFO usable for the next transaction.
- Open write transaction (2 pushes), then silence for TIMEOUT cycles -> abort, uncommitted words discarded, FSM IDLE, irq_err, stat_tout=1.
- Reset mid-read after 1 pop -> all outputs return to reset values, phy_addr=7'h40, tx_cnt=0.
